// File: rtl/hall_filter_decode_module.sv
// Hall sensor front end: per-channel synchroniser and glitch filter, sector
// decode with legality check, step direction and edge-to-edge period measure.
module hall_filter_decode_module #(
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned FILT_LEN    = 16,
    parameter int unsigned FILT_CNT_W  = 8,
    parameter int unsigned PERIOD_W    = 24
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                hall_u_in,
    input  logic                hall_v_in,
    input  logic                hall_w_in,
    output logic                hall_u_out,
    output logic                hall_v_out,
    output logic                hall_w_out,
    output logic [2:0]          sector,
    output logic                hall_valid,
    output logic                edge_pulse,
    output logic                dir,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                hall_err,
    output logic                stall
);

    localparam logic [FILT_CNT_W-1:0] FiltLast = FILT_CNT_W'(FILT_LEN - 1);
    localparam logic [PERIOD_W-1:0]   PcntMax  = '1;

    typedef enum logic [1:0] {StInit, StArmed, StRun} state_e;

    // Channel index 2 = U, 1 = V, 0 = W so the vector reads as {u,v,w}.
    logic [2:0]                         pins;
    logic [2:0][SYNC_STAGES-1:0]        sync_q;
    logic [2:0]                         synced;
    logic [2:0]                         filt_q, filt_d;
    logic [2:0][FILT_CNT_W-1:0]         fcnt_q, fcnt_d;

    state_e                             state_q;
    logic [2:0]                         sector_q, sector_d;
    logic                               hall_valid_q;
    logic                               edge_q, pv_q, err_q, dir_q, stall_q;
    logic [PERIOD_W-1:0]                period_q, pcnt_q;
    logic [2:0]                         fwd_sector, rev_sector;
    logic                               is_fwd, is_rev;

    assign pins = {hall_u_in, hall_v_in, hall_w_in};

    function automatic logic [2:0] decode(input logic [2:0] code);
        logic [2:0] s;
        case (code)
            3'b100:  s = 3'd1;
            3'b110:  s = 3'd2;
            3'b010:  s = 3'd3;
            3'b011:  s = 3'd4;
            3'b001:  s = 3'd5;
            3'b101:  s = 3'd6;
            default: s = 3'd0;
        endcase
        return s;
    endfunction

    // Metastability chains, one per channel.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], pins[ch]};
            end
        end
    end

    // A synced level must disagree with the filtered level for FILT_LEN cycles in a row.
    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            synced[ch] = sync_q[ch][SYNC_STAGES-1];
            filt_d[ch] = filt_q[ch];
            fcnt_d[ch] = '0;
            if (synced[ch] != filt_q[ch]) begin
                if (fcnt_q[ch] == FiltLast) begin
                    filt_d[ch] = synced[ch];
                end else begin
                    fcnt_d[ch] = fcnt_q[ch] + 1'b1;
                end
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            filt_q <= '0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Decode filtered code and classify it against the registered sector.
    always_comb begin
        sector_d   = decode(filt_q);
        fwd_sector = (sector_q == 3'd6) ? 3'd1 : sector_q + 3'd1;
        rev_sector = (sector_q == 3'd1) ? 3'd6 : sector_q - 3'd1;
        is_fwd     = (sector_d == fwd_sector);
        is_rev     = (sector_d == rev_sector);
    end

    // Tracking FSM with registered sector, pulses, direction, period and stall.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= StInit;
            sector_q     <= 3'd0;
            hall_valid_q <= 1'b0;
            edge_q       <= 1'b0;
            pv_q         <= 1'b0;
            err_q        <= 1'b0;
            dir_q        <= 1'b1;
            period_q     <= '0;
            stall_q      <= 1'b0;
            pcnt_q       <= '0;
        end else begin
            edge_q       <= 1'b0;
            pv_q         <= 1'b0;
            err_q        <= 1'b0;
            sector_q     <= sector_d;
            hall_valid_q <= (sector_d != 3'd0);
            pcnt_q       <= (pcnt_q == PcntMax) ? pcnt_q : pcnt_q + PERIOD_W'(1);
            if (sector_d != sector_q) begin
                if (sector_d == 3'd0) begin
                    // Entering an illegal code drops the reference entirely.
                    err_q   <= 1'b1;
                    state_q <= StInit;
                end else if (sector_q == 3'd0 || state_q == StInit) begin
                    state_q <= StArmed;
                    pcnt_q  <= '0;
                end else if (is_fwd || is_rev) begin
                    edge_q  <= 1'b1;
                    dir_q   <= is_fwd;
                    pcnt_q  <= '0;
                    stall_q <= 1'b0;
                    state_q <= StRun;
                    // Only a full interval between two edges is reported.
                    if (state_q == StRun && pcnt_q != PcntMax) begin
                        period_q <= pcnt_q + PERIOD_W'(1);
                        pv_q     <= 1'b1;
                    end
                end else begin
                    // Skipped sector: restart measurement from the new sector.
                    err_q   <= 1'b1;
                    state_q <= StArmed;
                    pcnt_q  <= '0;
                end
            end else if (pcnt_q == PcntMax && state_q != StInit) begin
                stall_q <= 1'b1;
                if (state_q == StRun) begin
                    state_q <= StArmed;
                end
            end
        end
    end

    assign hall_u_out   = filt_q[2];
    assign hall_v_out   = filt_q[1];
    assign hall_w_out   = filt_q[0];
    assign sector       = sector_q;
    assign hall_valid   = hall_valid_q;
    assign edge_pulse   = edge_q;
    assign dir          = dir_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign hall_err     = err_q;
    assign stall        = stall_q;

endmodule

// File: tb/tb_hall_filter_decode_module.sv
// Directed bench: default instance for filtering/decode/period, and an
// 8-bit period instance on the same pins for stall behaviour.
module tb_hall_filter_decode_module;

    logic clk = 1'b0;
    logic rst;
    logic hu, hv, hw;

    logic        u_o, v_o, w_o, hvalid, edge_p, dir_o, pv, err, stall_o;
    logic [2:0]  sector;
    logic [23:0] period;

    logic        s_u, s_v, s_w, s_valid, s_edge, s_dir, s_pv, s_err, s_stall;
    logic [2:0]  s_sector;
    logic [7:0]  s_period;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0, pv_n = 0, err_n = 0, s_edge_n = 0, s_pv_n = 0;
    int eb, pb, rb;

    logic [2:0] fwd_codes [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    always #5 clk = ~clk;

    hall_filter_decode_module dut (
        .sys_clk(clk), .reset(rst),
        .hall_u_in(hu), .hall_v_in(hv), .hall_w_in(hw),
        .hall_u_out(u_o), .hall_v_out(v_o), .hall_w_out(w_o),
        .sector(sector), .hall_valid(hvalid), .edge_pulse(edge_p), .dir(dir_o),
        .period(period), .period_valid(pv), .hall_err(err), .stall(stall_o)
    );

    hall_filter_decode_module #(.PERIOD_W(8)) dut_s (
        .sys_clk(clk), .reset(rst),
        .hall_u_in(hu), .hall_v_in(hv), .hall_w_in(hw),
        .hall_u_out(s_u), .hall_v_out(s_v), .hall_w_out(s_w),
        .sector(s_sector), .hall_valid(s_valid), .edge_pulse(s_edge), .dir(s_dir),
        .period(s_period), .period_valid(s_pv), .hall_err(s_err), .stall(s_stall)
    );

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (edge_p) edge_n++;
        if (pv)     pv_n++;
        if (err)    err_n++;
        if (s_edge) s_edge_n++;
        if (s_pv)   s_pv_n++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hall(input logic [2:0] c);
        {hu, hv, hw} = c;
    endtask

    initial begin
        rst = 1'b1;
        set_hall(3'b000);
        tick(3);
        check_eq("rst_sector", 32'(sector), 0);
        check_eq("rst_valid", 32'(hvalid), 0);
        check_eq("rst_dir", 32'(dir_o), 1);
        check_eq("rst_period", 32'(period), 0);
        check_eq("rst_stall", 32'(stall_o), 0);
        check_eq("rst_u", 32'(u_o), 0);
        rst = 1'b0;
        tick(5);

        // Short glitch must be swallowed by the filter.
        eb = edge_n; rb = err_n;
        hu = 1'b1; tick(10);
        hu = 1'b0; tick(40);
        check_eq("glitch_u", 32'(u_o), 0);
        check_eq("glitch_edge", 32'(edge_n - eb), 0);
        check_eq("glitch_err", 32'(err_n - rb), 0);

        // Forward rotation at 1000-cycle spacing.
        eb = edge_n; pb = pv_n; rb = err_n;
        for (int k = 0; k < 6; k++) begin
            set_hall(fwd_codes[k]);
            tick(1000);
            check_eq($sformatf("fwd_sector%0d", k + 1), 32'(sector), 32'(k + 1));
        end
        check_eq("fwd_valid", 32'(hvalid), 1);
        check_eq("fwd_dir", 32'(dir_o), 1);
        check_eq("fwd_edges", 32'(edge_n - eb), 5);
        check_eq("fwd_pvs", 32'(pv_n - pb), 4);
        check_eq("fwd_period", 32'(period), 1000);
        check_eq("fwd_errs", 32'(err_n - rb), 0);

        // Reverse rotation at 500-cycle spacing.
        set_hall(3'b001); tick(500);
        check_eq("rev_sector5", 32'(sector), 5);
        check_eq("rev_dir", 32'(dir_o), 0);
        check_eq("rev_period_a", 32'(period), 1000);
        set_hall(3'b011); tick(500);
        check_eq("rev_sector4", 32'(sector), 4);
        check_eq("rev_period_b", 32'(period), 500);
        set_hall(3'b010); tick(500);
        check_eq("rev_sector3", 32'(sector), 3);
        check_eq("rev_period_c", 32'(period), 500);

        // Illegal code from sector 3, then recovery without an edge.
        eb = edge_n; rb = err_n;
        set_hall(3'b111); tick(100);
        check_eq("ill_sector", 32'(sector), 0);
        check_eq("ill_valid", 32'(hvalid), 0);
        check_eq("ill_err", 32'(err_n - rb), 1);
        set_hall(3'b010); tick(100);
        check_eq("ret_sector", 32'(sector), 3);
        check_eq("ret_valid", 32'(hvalid), 1);
        check_eq("ret_edges", 32'(edge_n - eb), 0);
        check_eq("ret_err", 32'(err_n - rb), 1);
        pb = pv_n;
        set_hall(3'b011); tick(100);
        check_eq("ret_step_edge", 32'(edge_n - eb), 1);
        check_eq("ret_step_pv", 32'(pv_n - pb), 0);
        check_eq("ret_step_dir", 32'(dir_o), 1);

        // Reverse down to sector 1, then skip 1->3.
        set_hall(3'b010); tick(200);
        set_hall(3'b110); tick(200);
        set_hall(3'b100); tick(200);
        check_eq("pre_skip_sector", 32'(sector), 1);
        check_eq("pre_skip_dir", 32'(dir_o), 0);
        eb = edge_n; pb = pv_n; rb = err_n;
        set_hall(3'b010); tick(100);
        check_eq("skip_err", 32'(err_n - rb), 1);
        check_eq("skip_edge", 32'(edge_n - eb), 0);
        check_eq("skip_dir", 32'(dir_o), 0);
        check_eq("skip_sector", 32'(sector), 3);
        set_hall(3'b011); tick(100);
        check_eq("post_skip_edge", 32'(edge_n - eb), 1);
        check_eq("post_skip_pv", 32'(pv_n - pb), 0);
        check_eq("post_skip_dir", 32'(dir_o), 1);

        // Stall on the 8-bit period instance.
        set_hall(3'b001); tick(50);
        check_eq("s_stall_clr", 32'(s_stall), 0);
        tick(300);
        check_eq("s_stall_set", 32'(s_stall), 1);
        check_eq("big_no_stall", 32'(stall_o), 0);
        eb = s_edge_n; pb = s_pv_n;
        set_hall(3'b101); tick(50);
        check_eq("s_stall_edge", 32'(s_edge_n - eb), 1);
        check_eq("s_stall_pv", 32'(s_pv_n - pb), 0);
        check_eq("s_stall_off", 32'(s_stall), 0);
        tick(50);
        set_hall(3'b100); tick(50);
        check_eq("s_pv_after", 32'(s_pv_n - pb), 1);
        check_eq("s_period", 32'(s_period), 100);

        // Reset in the middle of a transition.
        set_hall(3'b110); tick(10);
        rst = 1'b1; tick(1);
        check_eq("mid_rst_sector", 32'(sector), 0);
        check_eq("mid_rst_valid", 32'(hvalid), 0);
        check_eq("mid_rst_period", 32'(period), 0);
        check_eq("mid_rst_s_period", 32'(s_period), 0);
        check_eq("mid_rst_u", 32'(u_o), 0);
        check_eq("mid_rst_edge", 32'(edge_p), 0);
        check_eq("mid_rst_dir", 32'(dir_o), 1);
        check_eq("mid_rst_stall", 32'(s_stall), 0);
        rst = 1'b0;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
